pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//   Program-counter / fetch controller sitting downstream of the ALU. Consumes ALU out_val[0] as the
//   branch-taken flag (ALU produces 1/0 when its branch input is high) and produces the next
//   instruction address. Branch targets come from a small writable target LUT indexed by the
//   instruction's immediate field. Owns the start/done handshake with the testbench and a retired-instruction counter.
// PARAMETERS
//   PC_W        10   program counter width (instruction memory depth = 2**PC_W)
//   IDX_W       5    branch-target LUT index width (LUT depth = 2**IDX_W)
//   START_ADDR  0    PC value loaded on program start
//   CNT_W       16   retired-instruction counter width
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      program start request; rising edge (registered detect) launches a run
//   stall      in   1      hold PC, counter and state this cycle
//   halt_req   in   1      decoded halt/done instruction at current PC
//   branch     in   1      current instruction is a conditional branch (same signal driven to ALU)
//   alu_out    in   8      ALU out_val; only bit 0 used (branch taken when branch=1)
//   lut_idx    in   IDX_W  branch-target LUT index from instruction immediate
//   lut_we     in   1      LUT write enable
//   lut_waddr  in   IDX_W  LUT write address
//   lut_wdata  in   PC_W   LUT write data (absolute target address)
//   pc         out  PC_W   current instruction address
//   running    out  1      1 while in RUN
//   done       out  1      1 while in HALTED
//   retired    out  CNT_W  instructions retired in current run
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, pc=0, done=0, running=0, retired=0, start_q=0, all LUT entries=0.
//   start_rise = start & ~start_q; start_q <= start every cycle (stall does not affect start_q).
//   States: IDLE, RUN, HALTED.
//   IDLE:   start_rise -> next edge pc<=START_ADDR, retired<=0, state<=RUN. Otherwise hold.
//   RUN (stall=0), priority order:
//     1. halt_req            -> state<=HALTED, pc holds, retired+=1 (halt counts as retired).
//     2. branch & alu_out[0] -> pc<=LUT[lut_idx], retired+=1.
//     3. otherwise           -> pc<=pc+1, modulo 2**PC_W (max wraps to 0), retired+=1.
//     branch=1 with alu_out[0]=0 is not-taken (case 3); alu_out[7:1] ignored always.
//     alu_out[0] ignored when branch=0.
//   RUN (stall=1): pc, retired, state all hold; halt_req/branch ignored that cycle.
//   HALTED: done=1, pc and retired hold. start_rise -> pc<=START_ADDR, retired<=0, state<=RUN.
//   start_rise while in RUN: ignored (no restart mid-run).
//   retired saturates at 2**CNT_W-1 (no wrap).
//   Outputs registered: running=(state==RUN), done=(state==HALTED), decoded from state register.
//   Latency: pc updates one edge after the qualifying inputs; LUT write visible to reads next cycle.
//   LUT write/read same index same cycle: branch uses OLD entry. LUT writes allowed in every state,
//   including during stall.
//   stall has no effect in IDLE/HALTED (start_rise still honoured).
//   Reset asserted mid-run: immediate return to reset values; LUT contents lost.
// TESTING
//   reset, pulse start (START_ADDR=0), no branch/halt 5 cycles -> pc 0,1,2,3,4,5; running=1; retired=5.
//   LUT[3]=10'h155; at pc=7 branch=1, alu_out=8'h01, lut_idx=3 -> pc=0x155 next edge; alu_out=8'h00 -> pc=8.
//   branch=1, alu_out=8'hFE -> not taken (bit0=0), pc+1; branch=0, alu_out=1 -> pc+1.
//   halt_req & taken branch same cycle -> HALTED, done=1, pc unchanged; start held high no re-run
//     until low->high; then pc=0, retired=0, done=0.
//   stall=1 for 3 cycles with halt_req=1 -> pc/retired frozen, no halt; pc=1023 unstalled -> pc=0.
//   LUT write idx 2 same cycle as taken branch idx 2 -> old target used; reset mid-run -> pc=0, IDLE, LUT=0.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-controller bus: run control, branch decode/ALU inputs, target-LUT write port, PC/status outputs.
// Pure wiring, no latency.
// No backpressure; stall is carried as an ordinary input.
interface pc_fetch_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
);
    logic             i_start;
    logic             i_stall;
    logic             i_halt_req;
    logic             i_branch;
    logic [7:0]       i_alu_out;
    logic [IDX_W-1:0] i_lut_idx;
    logic             i_lut_we;
    logic [IDX_W-1:0] i_lut_waddr;
    logic [PC_W-1:0]  i_lut_wdata;
    logic [PC_W-1:0]  o_pc;
    logic             o_running;
    logic             o_done;
    logic [CNT_W-1:0] o_retired;

    // Driver side (instruction decode / test environment).
    modport master (
        output i_start, i_stall, i_halt_req, i_branch, i_alu_out,
        output i_lut_idx, i_lut_we, i_lut_waddr, i_lut_wdata,
        input  o_pc, o_running, o_done, o_retired
    );

    // Fetch-controller side.
    modport slave (
        input  i_start, i_stall, i_halt_req, i_branch, i_alu_out,
        input  i_lut_idx, i_lut_we, i_lut_waddr, i_lut_wdata,
        output o_pc, o_running, o_done, o_retired
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter/fetch controller: IDLE/RUN/HALTED FSM, branch-target LUT, saturating retire counter.
// PC, state and counter update one edge after qualifying inputs; LUT writes visible the next cycle.
// stall freezes PC/counter/state in RUN only; start edge detect and LUT writes are never stalled.
module pc_fetch_ctrl #(
    parameter int PC_W       = 10,
    parameter int IDX_W      = 5,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input logic             i_clk,
    input logic             i_reset,
    pc_fetch_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    localparam int              LUT_D    = 1 << IDX_W;
    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] w_retired_nxt;
    logic [CNT_W-1:0] w_retired_inc;
    logic             r_start_q;
    logic             w_start_rise;
    logic             w_taken;
    logic [PC_W-1:0]  w_lut_rd;
    logic [PC_W-1:0]  r_lut [LUT_D];

    // Only the taken flag of the ALU result matters here.
    logic w_unused_alu;
    assign w_unused_alu = ^bus.i_alu_out[7:1];

    assign w_start_rise  = bus.i_start & ~r_start_q;
    assign w_taken       = bus.i_branch & bus.i_alu_out[0];
    // Read before any same-cycle write lands, so a colliding branch sees the old target.
    assign w_lut_rd      = r_lut[bus.i_lut_idx];
    assign w_retired_inc = (r_retired == {CNT_W{1'b1}}) ? r_retired : r_retired + 1'b1;

    // Next-state, next-PC and next-count decode; everything holds unless a rule below fires.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_retired_nxt = r_retired;
        unique case (r_state)
            S_IDLE, S_HALTED: begin
                if (w_start_rise) begin
                    w_state_nxt   = S_RUN;
                    w_pc_nxt      = START_PC;
                    w_retired_nxt = '0;
                end
            end
            S_RUN: begin
                if (!bus.i_stall) begin
                    w_retired_nxt = w_retired_inc;
                    if (bus.i_halt_req) begin
                        w_state_nxt = S_HALTED;
                    end else if (w_taken) begin
                        w_pc_nxt = w_lut_rd;
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC, counter and start-edge history registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_retired <= '0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_retired <= w_retired_nxt;
            r_start_q <= bus.i_start;
        end
    end

    // Branch-target LUT: writable in any state, cleared by reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < LUT_D; i++) begin
                r_lut[i] <= '0;
            end
        end else if (bus.i_lut_we) begin
            r_lut[bus.i_lut_waddr] <= bus.i_lut_wdata;
        end
    end

    assign bus.o_pc      = r_pc;
    assign bus.o_retired = r_retired;
    assign bus.o_running = (r_state == S_RUN);
    assign bus.o_done    = (r_state == S_HALTED);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: stimulus pushes expected outputs, a monitor pops and compares.
// Each vector's expectation is checked 1 time unit after the rising edge it applies to.
// No backpressure; the expectation queue is drained with a bounded wait before the summary.
module tb_pc_fetch_ctrl;
    localparam int PC_W  = 10;
    localparam int IDX_W = 5;
    localparam int CNT_W = 5;   // small counter so saturation is reachable quickly

    logic clk;
    logic reset;

    pc_fetch_ctrl_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(
        .PC_W(PC_W), .IDX_W(IDX_W), .START_ADDR(0), .CNT_W(CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [PC_W-1:0]  pc;
        logic             run;
        logic             done;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle of inputs on the falling edge and queue the outputs expected after the next rise.
    task automatic cyc(input string nm, input logic st, input logic sl, input logic hr,
                       input logic br, input logic [7:0] alu, input logic [IDX_W-1:0] idx,
                       input logic we, input logic [IDX_W-1:0] wa, input logic [PC_W-1:0] wd,
                       input logic [PC_W-1:0] e_pc, input logic e_run, input logic e_done,
                       input logic [CNT_W-1:0] e_ret);
        exp_t e;
        @(negedge clk);
        bus.i_start     = st;
        bus.i_stall     = sl;
        bus.i_halt_req  = hr;
        bus.i_branch    = br;
        bus.i_alu_out   = alu;
        bus.i_lut_idx   = idx;
        bus.i_lut_we    = we;
        bus.i_lut_waddr = wa;
        bus.i_lut_wdata = wd;
        e.name = nm;
        e.pc   = e_pc;
        e.run  = e_run;
        e.done = e_done;
        e.ret  = e_ret;
        sb_q.push_back(e);
    endtask

    // Monitor: after each rising edge, compare the DUT against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.o_pc !== e.pc || bus.o_running !== e.run ||
                    bus.o_done !== e.done || bus.o_retired !== e.ret) begin
                    errors++;
                    $display("FAIL %s: got pc=%h run=%b done=%b ret=%0d, want pc=%h run=%b done=%b ret=%0d",
                             e.name, bus.o_pc, bus.o_running, bus.o_done, bus.o_retired,
                             e.pc, e.run, e.done, e.ret);
                end
            end
        end
    end

    initial begin
        int sat_ret;
        reset = 1'b1;
        bus.i_start = 0; bus.i_stall = 0; bus.i_halt_req = 0; bus.i_branch = 0;
        bus.i_alu_out = '0; bus.i_lut_idx = '0; bus.i_lut_we = 0;
        bus.i_lut_waddr = '0; bus.i_lut_wdata = '0;

        //    name         st sl hr br alu    idx we wa wd      pc      run done ret
        cyc("reset",       0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 0, 0, 0);
        @(posedge clk); #2 reset = 1'b0;
        cyc("idle_hold",   0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 0, 0, 0);
        cyc("start",       1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 1, 0, 0);
        cyc("seq1_wr3",    1, 0, 0, 0, 8'h00, 0, 1, 3, 10'h155,10'h001, 1, 0, 1);
        cyc("seq2",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h002, 1, 0, 2);
        cyc("seq3",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h003, 1, 0, 3);
        cyc("seq4",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h004, 1, 0, 4);
        cyc("seq5",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h005, 1, 0, 5);
        cyc("seq6",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h006, 1, 0, 6);
        cyc("seq7",        1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h007, 1, 0, 7);
        cyc("br_nt_00",    1, 0, 0, 1, 8'h00, 3, 0, 0, 10'h0,  10'h008, 1, 0, 8);
        cyc("br_taken",    1, 0, 0, 1, 8'h01, 3, 0, 0, 10'h0,  10'h155, 1, 0, 9);
        cyc("br_nt_00b",   1, 0, 0, 1, 8'h00, 3, 0, 0, 10'h0,  10'h156, 1, 0, 10);
        cyc("br_nt_fe",    1, 0, 0, 1, 8'hFE, 3, 0, 0, 10'h0,  10'h157, 1, 0, 11);
        cyc("nobr_alu1",   1, 0, 0, 0, 8'h01, 3, 0, 0, 10'h0,  10'h158, 1, 0, 12);
        for (int i = 0; i < 3; i++)
            cyc("stall_halt",1, 1, 1, 1, 8'h01, 3, 0, 0, 10'h0,  10'h158, 1, 0, 12);
        cyc("wr2_3ff",     1, 0, 0, 0, 8'h00, 0, 1, 2, 10'h3FF,10'h159, 1, 0, 13);
        cyc("rw_same_old", 1, 0, 0, 1, 8'h01, 2, 1, 2, 10'h020,10'h3FF, 1, 0, 14);
        cyc("pc_wrap",     1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 1, 0, 15);
        cyc("br_new_lut",  1, 0, 0, 1, 8'h01, 2, 0, 0, 10'h0,  10'h020, 1, 0, 16);
        cyc("halt_and_br", 1, 0, 1, 1, 8'h01, 2, 0, 0, 10'h0,  10'h020, 0, 1, 17);
        cyc("halt_st_hi1", 1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h020, 0, 1, 17);
        cyc("halt_st_hi2", 1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h020, 0, 1, 17);
        cyc("halt_st_lo",  0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h020, 0, 1, 17);
        cyc("restart_stl", 1, 1, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 1, 0, 0);
        cyc("rerun1",      1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h001, 1, 0, 1);
        cyc("run_st_lo",   0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h002, 1, 0, 2);
        cyc("run_st_rise", 1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h003, 1, 0, 3);

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #2 reset = 1'b1;
        cyc("reset_mid",   1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 0, 0, 0);
        @(posedge clk); #2 reset = 1'b0;
        cyc("idle2",       0, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 0, 0, 0);
        cyc("start2",      1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  10'h000, 1, 0, 0);
        cyc("lut2_clr",    1, 0, 0, 1, 8'h01, 2, 0, 0, 10'h0,  10'h000, 1, 0, 1);
        cyc("lut3_clr",    1, 0, 0, 1, 8'h01, 3, 0, 0, 10'h0,  10'h000, 1, 0, 2);

        // Straight-line run until the retire counter pins at its maximum.
        for (int i = 1; i <= 32; i++) begin
            sat_ret = (2 + i > 31) ? 31 : 2 + i;
            cyc("saturate",  1, 0, 0, 0, 8'h00, 0, 0, 0, 10'h0,  PC_W'(i), 1, 0, CNT_W'(sat_ret));
        end
        cyc("halt_sat",    1, 0, 1, 0, 8'h00, 0, 0, 0, 10'h0,  10'h020, 0, 1, 31);

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
